// File: rtl/cdb_pkg.sv
// Shared constants and types for the common-data-bus writeback arbiter.
package cdb_pkg;

    typedef logic [1:0] src_t;

    localparam src_t SRC_ADD  = 2'd0;
    localparam src_t SRC_MULT = 2'd1;
    localparam src_t SRC_LOAD = 2'd2;
    localparam int   NUM_SRC  = 3;

    localparam int TAG_W = 8;
    localparam int VAL_W = 32;

    // (a + b) mod NUM_SRC for source indices already in range.
    function automatic src_t src_add(input src_t a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'(NUM_SRC)) ? src_t'(s - 3'(NUM_SRC)) : src_t'(s);
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO: synchronous, show-ahead head, push/pop in the same cycle allowed.
module cdb_fifo #(
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Three-source result-bus arbiter onto one registered broadcast bus.
// Optional macro CDB_LOAD_PRIORITY_EN: load FIFO always wins, add/mult round-robin.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_valid,
    input  logic [DATA_W-1:0] add_data,
    output logic              add_ready,
    input  logic              mult_valid,
    input  logic [DATA_W-1:0] mult_data,
    output logic              mult_ready,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_bus,
    output logic [1:0]        cdb_src,
    input  logic              cdb_ready
);

    logic [NUM_SRC-1:0] valid_v, ready_v, push_v, pop_v, full_v, empty_v, req;
    logic [DATA_W-1:0]  data_v [NUM_SRC];
    logic [DATA_W-1:0]  head_v [NUM_SRC];
    src_t               rr_ptr, grant, cand;
    logic               grant_vld, load_out;

    assign valid_v          = {load_valid, mult_valid, add_valid};
    assign data_v[SRC_ADD]  = add_data;
    assign data_v[SRC_MULT] = mult_data;
    assign data_v[SRC_LOAD] = load_data;

    // A full FIFO stays not-ready even if it pops this cycle.
    assign ready_v    = rst ? '0 : ~full_v;
    assign push_v     = valid_v & ready_v;
    assign add_ready  = ready_v[SRC_ADD];
    assign mult_ready = ready_v[SRC_MULT];
    assign load_ready = ready_v[SRC_LOAD];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        cdb_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_v[i]),
            .pop   (pop_v[i]),
            .data  (data_v[i]),
            .head  (head_v[i]),
            .full  (full_v[i]),
            .empty (empty_v[i])
        );
    end

    always_comb begin
        req       = ~empty_v;
        grant_vld = 1'b0;
        grant     = rr_ptr;
        cand      = rr_ptr;
`ifdef CDB_LOAD_PRIORITY_EN
        if (req[SRC_LOAD]) begin
            grant_vld = 1'b1;
            grant     = SRC_LOAD;
        end
        req[SRC_LOAD] = 1'b0;
`endif
        for (int off = 0; off < NUM_SRC; off++) begin
            cand = src_add(rr_ptr, 2'(off));
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    assign load_out = !cdb_valid || cdb_ready;
    assign pop_v    = (grant_vld && load_out) ? (NUM_SRC'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_bus   <= '0;
            cdb_src   <= '0;
            rr_ptr    <= SRC_ADD;
        end else if (load_out) begin
            cdb_valid <= grant_vld;
            if (grant_vld) begin
                cdb_bus <= head_v[grant];
                cdb_src <= grant;
`ifdef CDB_LOAD_PRIORITY_EN
                if (grant != SRC_LOAD) rr_ptr <= src_add(grant, 2'd1);
`else
                rr_ptr <= src_add(grant, 2'd1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle plus directed literal cases.
module tb_cdb_arbiter;

    localparam int DW    = 40;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          add_valid = 1'b0, mult_valid = 1'b0, load_valid = 1'b0;
    logic [DW-1:0] add_data = '0, mult_data = '0, load_data = '0;
    logic          add_ready, mult_ready, load_ready;
    logic          cdb_valid;
    logic [DW-1:0] cdb_bus;
    logic [1:0]    cdb_src;
    logic          cdb_ready = 1'b1;

    cdb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_data(add_data), .add_ready(add_ready),
        .mult_valid(mult_valid), .mult_data(mult_data), .mult_ready(mult_ready),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .cdb_valid(cdb_valid), .cdb_bus(cdb_bus), .cdb_src(cdb_src), .cdb_ready(cdb_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: one queue per source, one output slot, round-robin pointer.
    logic [DW-1:0] qa[$], qm[$], ql[$];
    logic          m_vld = 1'b0;
    logic [DW-1:0] m_bus = '0;
    int            m_src = 0;
    int            m_rr  = 0;
    bit            m_started = 0;

    function automatic int qsize(input int s);
        case (s)
            0:       return qa.size();
            1:       return qm.size();
            default: return ql.size();
        endcase
    endfunction

    function automatic logic [DW-1:0] qpop(input int s);
        case (s)
            0:       return qa.pop_front();
            1:       return qm.pop_front();
            default: return ql.pop_front();
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_started = 1;
            if (rst) begin
                qa.delete(); qm.delete(); ql.delete();
                m_vld = 0; m_bus = '0; m_src = 0; m_rr = 0;
            end else begin
                int  sz [3];
                int  g;
                bit  rdy [3];
                for (int s = 0; s < 3; s++) begin
                    sz[s]  = qsize(s);
                    rdy[s] = (sz[s] != DEPTH);
                end
                if (!m_vld || cdb_ready) begin
                    g = -1;
`ifdef CDB_LOAD_PRIORITY_EN
                    if (sz[2] > 0) g = 2;
                    for (int off = 0; off < 3; off++)
                        if (g < 0 && (m_rr + off) % 3 != 2 && sz[(m_rr + off) % 3] > 0)
                            g = (m_rr + off) % 3;
`else
                    for (int off = 0; off < 3; off++)
                        if (g < 0 && sz[(m_rr + off) % 3] > 0)
                            g = (m_rr + off) % 3;
`endif
                    if (g >= 0) begin
                        m_vld = 1;
                        m_bus = qpop(g);
                        m_src = g;
`ifdef CDB_LOAD_PRIORITY_EN
                        if (g != 2) m_rr = (g + 1) % 3;
`else
                        m_rr = (g + 1) % 3;
`endif
                    end else begin
                        m_vld = 0;
                    end
                end
                if (add_valid  && rdy[0]) qa.push_back(add_data);
                if (mult_valid && rdy[1]) qm.push_back(mult_data);
                if (load_valid && rdy[2]) ql.push_back(load_data);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("cdb_valid", 64'(cdb_valid), 64'(m_vld));
                chk("cdb_bus", 64'(cdb_bus), 64'(m_bus));
                chk("cdb_src", 64'(cdb_src), 64'(m_src));
                chk("add_ready", 64'(add_ready), 64'(!rst && qa.size() != DEPTH));
                chk("mult_ready", 64'(mult_ready), 64'(!rst && qm.size() != DEPTH));
                chk("load_ready", 64'(load_ready), 64'(!rst && ql.size() != DEPTH));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        add_valid = 0; mult_valid = 0; load_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        cdb_ready = 1;
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {8'($urandom), 32'($urandom)};
    endfunction

    localparam logic [DW-1:0] WA = 40'h10_AAAA_0001;
    localparam logic [DW-1:0] WB = 40'h11_BBBB_0002;
    localparam logic [DW-1:0] WC = 40'h12_CCCC_0003;

    initial begin
        int exp_src [3];

        // Reset with all valids asserted
        rst = 1; cdb_ready = 1;
        add_valid = 1; mult_valid = 1; load_valid = 1;
        add_data = WA; mult_data = WB; load_data = WC;
        tick(); tick();
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_bus", 64'(cdb_bus), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_readies", 64'({add_ready, mult_ready, load_ready}), 64'd0);
        idle_inputs();
        rst = 0;
        #1;
        chk("post_rst_readies", 64'({add_ready, mult_ready, load_ready}), 64'b111);
        tick(); tick();

        // Single result: two-cycle latency, one-cycle broadcast
        do_reset();
        add_valid = 1; add_data = 40'h03_0000_0091;
        tick();
        add_valid = 0;
        chk("single_not_yet", 64'(cdb_valid), 64'd0);
        tick();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_bus", 64'(cdb_bus), 64'h03_0000_0091);
        chk("single_src", 64'(cdb_src), 64'd0);
        tick();
        chk("single_done", 64'(cdb_valid), 64'd0);

        // Simultaneous arrival on all three sources
        do_reset();
        add_valid = 1; mult_valid = 1; load_valid = 1;
        add_data = 40'h01_0000_00A0; mult_data = 40'h02_0000_00B0; load_data = 40'h03_0000_00C0;
        tick();
        idle_inputs();
`ifdef CDB_LOAD_PRIORITY_EN
        exp_src = '{2, 0, 1};
`else
        exp_src = '{0, 1, 2};
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("simul_valid", 64'(cdb_valid), 64'd1);
            chk("simul_src", 64'(cdb_src), 64'(exp_src[i]));
            chk("simul_tag", 64'(cdb_bus[39:32]), 64'(exp_src[i] + 1));
        end
        tick();
        chk("simul_done", 64'(cdb_valid), 64'd0);

        // Fairness: add and load continuously valid
        do_reset();
        add_valid = 1; load_valid = 1;
        add_data = rnd_word(); load_data = rnd_word();
        tick();
        for (int i = 0; i < 10; i++) begin
            add_data = rnd_word(); load_data = rnd_word();
            tick();
            chk("fair_valid", 64'(cdb_valid), 64'd1);
`ifdef CDB_LOAD_PRIORITY_EN
            chk("fair_src", 64'(cdb_src), 64'd2);
`else
            chk("fair_src", 64'(cdb_src), (i % 2 == 0) ? 64'd0 : 64'd2);
`endif
        end
`ifdef CDB_LOAD_PRIORITY_EN
        load_valid = 0;
        tick(); tick();
        chk("prio_add_resumes", 64'(cdb_src), 64'd0);
`endif
        idle_inputs();
        tick(); tick(); tick(); tick(); tick();

        // Backpressure, then reset while full
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            cdb_ready = 0;
            add_valid = 1; add_data = WA; tick();
            add_data = WB; tick();
            add_data = WC; tick();
            add_valid = 0;
            chk("bp_valid", 64'(cdb_valid), 64'd1);
            chk("bp_bus_held", 64'(cdb_bus), 64'(WA));
            chk("bp_add_ready", 64'(add_ready), 64'd0);
            tick();
            chk("bp_bus_still", 64'(cdb_bus), 64'(WA));
            if (rep == 0) begin
                cdb_ready = 1;
                tick();
                chk("bp_second", 64'(cdb_bus), 64'(WB));
                tick();
                chk("bp_third", 64'(cdb_bus), 64'(WC));
                chk("bp_third_valid", 64'(cdb_valid), 64'd1);
                tick();
                chk("bp_drained", 64'(cdb_valid), 64'd0);
            end else begin
                rst = 1;
                tick();
                chk("rst_flush_valid", 64'(cdb_valid), 64'd0);
                rst = 0;
                cdb_ready = 1;
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk("rst_nothing_after", 64'(cdb_valid), 64'd0);
                end
            end
        end

        // Randomised traffic with occasional backpressure and reset
        for (int i = 0; i < 3000; i++) begin
            add_valid  = ($urandom_range(99) < 50);
            mult_valid = ($urandom_range(99) < 40);
            load_valid = ($urandom_range(99) < 45);
            add_data   = rnd_word();
            mult_data  = rnd_word();
            load_data  = rnd_word();
            cdb_ready  = ($urandom_range(99) < 70);
            rst        = ($urandom_range(999) < 8);
            tick();
        end
        rst = 0;
        idle_inputs();
        cdb_ready = 1;
        tick(); tick(); tick(); tick();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
